// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: pipeline writeback, LU result handshake,
// register-file write port and the hazard/status outputs.
// The arbiter connects through the slave modport. The writeback stage, the LU
// and the register file connect through the master modport.
// XLEN and DEPTH must match the parameters of the arbiter that uses this bundle.
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            lu_valid_i;
  logic            lu_ready_o;
  logic [4:0]      lu_rd_i;
  logic [XLEN-1:0] lu_data_i;
  logic            rf_we_o;
  logic [4:0]      rf_rd_o;
  logic [XLEN-1:0] rf_data_o;
  logic            pipe_hold_o;
  logic [31:0]     pend_mask_o;
  logic [CW-1:0]   fifo_cnt_o;

  modport slave (
    input  wb_we_i, wb_rd_i, wb_data_i, lu_valid_i, lu_rd_i, lu_data_i,
    output lu_ready_o, rf_we_o, rf_rd_o, rf_data_o, pipe_hold_o, pend_mask_o, fifo_cnt_o
  );

  modport master (
    output wb_we_i, wb_rd_i, wb_data_i, lu_valid_i, lu_rd_i, lu_data_i,
    input  lu_ready_o, rf_we_o, rf_rd_o, rf_data_o, pipe_hold_o, pend_mask_o, fifo_cnt_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between
// in-order pipeline writeback (absolute priority) and one long-latency unit
// whose results are queued in a DEPTH-entry FIFO and drained on idle port cycles.
// A starvation FSM raises pipe_hold_o when the FIFO head has been blocked
// STARVE_MAX times, and releases it once the FIFO is empty.
// Optional feature macro: WBARB_BYPASS_EN. When it is defined, an LU result
// arriving while the FIFO is empty and the port is free goes straight to the
// port in the same cycle and is never queued.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} starve_state_e;

  logic [4:0]      r_rd_mem   [DEPTH];
  logic [XLEN-1:0] r_data_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  starve_state_e   r_state;
  logic [SW-1:0]   r_starve;

  logic            w_wb_win;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_bypass;
  logic            w_ready;
  logic            w_push;
  logic [CW-1:0]   w_cnt_nxt;
  starve_state_e   w_state_nxt;
  logic [SW-1:0]   w_starve_nxt;

  // A pipeline write to x0 never claims the port.
  assign w_wb_win = bus.wb_we_i && (bus.wb_rd_i != 5'd0);
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CW'(DEPTH));
  // The head drains whenever the pipeline leaves the port free; independent of lu_valid_i.
  assign w_pop    = !w_wb_win && !w_empty;

`ifdef WBARB_BYPASS_EN
  assign w_bypass = w_empty && !w_wb_win && bus.lu_valid_i && (bus.lu_rd_i != 5'd0);
`else
  assign w_bypass = 1'b0;
`endif

  // Held low while in reset; a full FIFO can still take a result in the cycle it pops.
  assign w_ready  = rst_ni && (!w_full || w_pop);
  // rd=0 results complete the handshake but are dropped; bypassed results are not queued.
  assign w_push   = bus.lu_valid_i && w_ready && (bus.lu_rd_i != 5'd0) && !w_bypass;

  assign w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);

  assign bus.lu_ready_o  = w_ready;
  assign bus.fifo_cnt_o  = r_cnt;
  assign bus.pipe_hold_o = (r_state == S_HOLD);

  // Port mux: pipeline, then FIFO head, then (bypass build) the live LU result.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    bus.rf_we_o   = 1'b0;
    bus.rf_rd_o   = 5'd0;
    bus.rf_data_o = '0;
    if (rst_ni) begin
      if (w_wb_win) begin
        bus.rf_we_o   = 1'b1;
        bus.rf_rd_o   = bus.wb_rd_i;
        bus.rf_data_o = bus.wb_data_i;
      end else if (w_pop) begin
        bus.rf_we_o   = 1'b1;
        bus.rf_rd_o   = r_rd_mem[r_rptr];
        bus.rf_data_o = r_data_mem[r_rptr];
      end else if (w_bypass) begin
        bus.rf_we_o   = 1'b1;
        bus.rf_rd_o   = bus.lu_rd_i;
        bus.rf_data_o = bus.lu_data_i;
      end
    end
  end

  // FIFO pointers and occupancy; reset discards all queued results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= w_cnt_nxt;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= bus.lu_rd_i;
      r_data_mem[r_wptr] <= bus.lu_data_i;
    end
  end

  // Pending-rd mask rebuilt from the occupied slots, so it follows registered FIFO state.
  always_comb begin
    logic [AW-1:0] v_off;
    bus.pend_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = AW'(i) - r_rptr;
      if (CW'(v_off) < r_cnt) bus.pend_mask_o[r_rd_mem[i]] = 1'b1;
    end
    bus.pend_mask_o[0] = 1'b0;
  end

  // Starvation FSM state and blocked-cycle counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Starvation next-state: count head-blocked cycles, hold the pipe at STARVE_MAX until drained.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    unique case (r_state)
      S_IDLE: begin
        w_starve_nxt = '0;
        if (w_cnt_nxt != '0) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_pop) begin
          w_starve_nxt = '0;
          if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
        end else if (!w_empty && w_wb_win) begin
          if (r_starve >= SW'(STARVE_MAX - 1)) begin
            w_starve_nxt = SW'(STARVE_MAX);
            w_state_nxt  = S_HOLD;
          end else begin
            w_starve_nxt = r_starve + SW'(1);
          end
        end
      end
      S_HOLD: begin
        if (w_cnt_nxt == '0) begin
          w_state_nxt  = S_IDLE;
          w_starve_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_starve_nxt = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. The reference model is a queue of
// pending LU results, a blocked-cycle count and a hold flag, updated once per
// cycle from the arbitration rules. Directed scenarios come first, then random traffic.
module tb_wb_port_arbiter;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t mq[$];
  int   m_starve = 0;
  bit   m_hold   = 0;
  bit   last_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_hold   = 0;
  endtask

  // Drive one cycle of inputs, compare every output against the model, then advance the model.
  task automatic tick(input string tag, input logic we, input logic [4:0] rd, input logic [XLEN-1:0] d,
                      input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
    bit win, pop, byp, rdy, blocked;
    logic e_we;
    logic [4:0] e_rd;
    logic [XLEN-1:0] e_d;
    logic [31:0] e_mask;
    @(negedge clk);
    bus.wb_we_i = we;  bus.wb_rd_i = rd;  bus.wb_data_i = d;
    bus.lu_valid_i = lv; bus.lu_rd_i = lrd; bus.lu_data_i = ld;
    #1;
    win = we && (rd != 5'd0);
    pop = !win && (mq.size() > 0);
    byp = 1'b0;
`ifdef WBARB_BYPASS_EN
    byp = !win && (mq.size() == 0) && lv && (lrd != 5'd0);
`endif
    e_we = 1'b0; e_rd = 5'd0; e_d = '0;
    if (win) begin
      e_we = 1'b1; e_rd = rd; e_d = d;
    end else if (pop) begin
      e_we = 1'b1; e_rd = mq[0].rd; e_d = mq[0].data;
    end else if (byp) begin
      e_we = 1'b1; e_rd = lrd; e_d = ld;
    end
    rdy = (mq.size() < DEPTH) || pop;
    e_mask = '0;
    foreach (mq[i]) e_mask[mq[i].rd] = 1'b1;
    e_mask[0] = 1'b0;
    check({tag, ".rf_we"},   bus.rf_we_o,     e_we);
    check({tag, ".rf_rd"},   bus.rf_rd_o,     e_rd);
    check({tag, ".rf_data"}, bus.rf_data_o,   e_d);
    check({tag, ".ready"},   bus.lu_ready_o,  rdy);
    check({tag, ".cnt"},     bus.fifo_cnt_o,  mq.size());
    check({tag, ".mask"},    bus.pend_mask_o, e_mask);
    check({tag, ".hold"},    bus.pipe_hold_o, m_hold);
    last_acc = lv && rdy;
    blocked  = (mq.size() > 0) && win;
    if (pop) void'(mq.pop_front());
    if (last_acc && (lrd != 5'd0) && !byp) mq.push_back('{rd: lrd, data: ld});
    if (mq.size() == 0) begin
      m_starve = 0;
      m_hold   = 0;
    end else if (!m_hold) begin
      if (pop) m_starve = 0;
      else if (blocked) begin
        m_starve++;
        if (m_starve >= STARVE_MAX) m_hold = 1;
      end
    end
  endtask

  initial begin
    logic [XLEN-1:0] ld;
    logic [4:0]      lrd;
    logic            lv;
    logic            we;
    bus.wb_we_i = 1'b1; bus.wb_rd_i = 5'd3; bus.wb_data_i = 32'h1234;
    bus.lu_valid_i = 1'b0; bus.lu_rd_i = 5'd0; bus.lu_data_i = '0;

    // Reset values, with a pipeline write present to show the port is forced idle.
    #2 rst_n = 1'b0;
    #1;
    check("rst.rf_we",   bus.rf_we_o,     1'b0);
    check("rst.rf_rd",   bus.rf_rd_o,     5'd0);
    check("rst.rf_data", bus.rf_data_o,   32'd0);
    check("rst.hold",    bus.pipe_hold_o, 1'b0);
    check("rst.mask",    bus.pend_mask_o, 32'd0);
    check("rst.cnt",     bus.fifo_cnt_o,  0);
    bus.wb_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle port, single LU result rd=5.
    tick("lu5",      1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5);
    tick("lu5_wr",   1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick("lu5_done", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Pipeline busy on rd=3 every cycle while LU streams rd=7 results.
    ld = 32'h700;
    for (int i = 0; i < 6; i++) begin
      tick("starve", 1'b1, 5'd3, 32'h300 + i, 1'b1, 5'd7, ld);
      if (last_acc) ld = ld + 1;
    end
    tick("drain_acc", 1'b0, 5'd0, '0, 1'b1, 5'd7, ld);
    for (int i = 0; i < 4; i++) tick("drain", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Full FIFO with the pipe idle: push and pop in the same cycle, order preserved.
    tick("fill",    1'b1, 5'd2, 32'h201, 1'b1, 5'd9, 32'h901);
    tick("fill",    1'b1, 5'd2, 32'h202, 1'b1, 5'd9, 32'h902);
    tick("full_pp", 1'b0, 5'd0, '0,      1'b1, 5'd9, 32'h903);
    tick("full_pp", 1'b0, 5'd0, '0,      1'b1, 5'd9, 32'h904);
    for (int i = 0; i < 3; i++) tick("full_drain", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Pipeline write to x0 leaves the port to the FIFO head.
    tick("x0_fill", 1'b1, 5'd2, 32'h222, 1'b1, 5'd4, 32'h404);
    tick("x0_pipe", 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, '0);
    tick("x0_idle", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // LU result for x0: accepted, never queued, never written.
    tick("lu_x0",      1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hBAD);
    tick("lu_x0_next", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Reset asserted mid-operation with two results pending.
    tick("pre_rst", 1'b1, 5'd2, 32'h1, 1'b1, 5'd11, 32'hB11);
    tick("pre_rst", 1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hC12);
    @(negedge clk);
    bus.wb_we_i = 1'b1; bus.wb_rd_i = 5'd2; bus.lu_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst.rf_we", bus.rf_we_o,     1'b0);
    check("midrst.rf_rd", bus.rf_rd_o,     5'd0);
    check("midrst.cnt",   bus.fifo_cnt_o,  0);
    check("midrst.mask",  bus.pend_mask_o, 32'd0);
    check("midrst.hold",  bus.pipe_hold_o, 1'b0);
    bus.wb_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) tick("post_rst", 1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

    // Random traffic; the LU keeps rd/data stable until its result is accepted.
    lv = 1'b0; lrd = 5'd0; ld = '0;
    for (int i = 0; i < 400; i++) begin
      if (!lv && ($urandom_range(0, 1) == 1)) begin
        lv  = 1'b1;
        lrd = 5'($urandom_range(0, 31));
        ld  = $urandom;
      end
      we = ($urandom_range(0, 99) < 60);
      tick("rand", we, 5'($urandom_range(0, 31)), $urandom, lv, lrd, ld);
      if (last_acc) lv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
